// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types and helpers for the round-robin shifter scheduler and the
// barrel shifter it drives.
//   shift_ctrl_e    : 3-bit shift control encoding (two codes are illegal)
//   buf_state_e     : output-buffer state (EMPTY / FULL)
//   is_illegal_ctrl : flags the two unused control codes
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [2:0] {
        SH_NONE     = 3'b000,
        SH_LSR      = 3'b001,
        SH_ASR      = 3'b010,
        SH_RSR_WRAP = 3'b011,
        SH_LSL      = 3'b100,
        SH_LSL_WRAP = 3'b110
    } shift_ctrl_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Codes 101 and 111 have no operation assigned; data passes through.
    function automatic logic is_illegal_ctrl(input logic [2:0] ctrl);
        return (ctrl == 3'b101) || (ctrl == 3'b111);
    endfunction

endpackage

// File: rtl/shifter_barrel.sv
// -----------------------------------------------------------------------------
// shifter_barrel
// Purely combinational barrel shifter shared by all requesters.
//   i_data [WIDTH] : operand
//   i_ctrl [3]     : shift control (see shift_ctrl_e)
//   i_amt  [AW]    : shift amount, AW = log2(WIDTH)+1
//   o_data [WIDTH] : shifted result (operand unchanged for illegal codes)
//   o_err          : high for an illegal control code
// -----------------------------------------------------------------------------
module shifter_barrel
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_ctrl,
    input  logic [AW-1:0]    i_amt,
    output logic [WIDTH-1:0] o_data,
    output logic             o_err
);

    localparam int SW = AW - 1;

    logic [SW-1:0]        w_modAmt;
    logic                 w_modZero;
    logic                 w_overRange;
    logic [2*WIDTH-1:0]   w_rorDbl;
    logic [2*WIDTH-1:0]   w_rolDbl;
    logic [WIDTH-1:0]     w_lsr;
    logic [WIDTH-1:0]     w_lsl;
    logic [WIDTH-1:0]     w_asr;

    // The low bits are the amount modulo WIDTH; the top bit alone tells us
    // the raw amount reached WIDTH, which clears a logical shift unless the
    // amount is an exact multiple of WIDTH (then the operand passes through).
    assign w_modAmt    = i_amt[SW-1:0];
    assign w_modZero   = (w_modAmt == '0);
    assign w_overRange = i_amt[AW-1];

    // Rotates come from a doubled operand so the wrapped bits fall into place.
    assign w_rorDbl = {i_data, i_data} >> w_modAmt;
    assign w_rolDbl = {i_data, i_data} << w_modAmt;

    assign w_lsr = w_modZero ? i_data : (w_overRange ? '0 : (i_data >> w_modAmt));
    assign w_lsl = w_modZero ? i_data : (w_overRange ? '0 : (i_data << w_modAmt));
    assign w_asr = $signed(i_data) >>> w_modAmt;

    // Select the operation; illegal codes fall to the default pass-through.
    always_comb begin
        o_data = i_data;
        case (i_ctrl)
            SH_NONE:     o_data = i_data;
            SH_LSR:      o_data = w_lsr;
            SH_ASR:      o_data = w_asr;
            SH_RSR_WRAP: o_data = w_rorDbl[WIDTH-1:0];
            SH_LSL:      o_data = w_lsl;
            SH_LSL_WRAP: o_data = w_rolDbl[2*WIDTH-1:WIDTH];
            default:     o_data = i_data;
        endcase
    end

    assign o_err = is_illegal_ctrl(i_ctrl);

endmodule

// File: rtl/shifter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// shifter_rr_scheduler
// Round-robin scheduler sharing one barrel shifter among N requesters, with a
// one-entry registered response buffer.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_req_valid/o_req_ready  : per-requester handshake (ready is one-hot or 0)
//   i_req_data/ctrl/amt      : packed per-requester operand, control, amount
//   o_rsp_valid/i_rsp_ready  : response handshake
//   o_rsp_data/id/err        : shifted result, requester index, illegal flag
// -----------------------------------------------------------------------------
module shifter_rr_scheduler
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int AW    = $clog2(WIDTH) + 1,
    localparam int IDW   = $clog2(N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N-1:0]       i_req_valid,
    output logic [N-1:0]       o_req_ready,
    input  logic [N*WIDTH-1:0] i_req_data,
    input  logic [N*3-1:0]     i_req_ctrl,
    input  logic [N*AW-1:0]    i_req_amt,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [WIDTH-1:0]   o_rsp_data,
    output logic [IDW-1:0]     o_rsp_id,
    output logic               o_rsp_err
);

    localparam logic [IDW:0] NVAL = (IDW+1)'(N);

    buf_state_e         r_state;
    buf_state_e         w_nextState;
    logic [IDW-1:0]     r_rrPtr;
    logic [WIDTH-1:0]   r_rspData;
    logic [IDW-1:0]     r_rspId;
    logic               r_rspErr;

    logic               w_canAccept;
    logic               w_grant;
    logic [2*N-1:0]     w_validDbl;
    logic [N-1:0]       w_validRot;
    logic [IDW-1:0]     w_offset;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_grantIdx;
    logic [IDW-1:0]     w_nextPtr;
    logic [WIDTH-1:0]   w_selData;
    logic [2:0]         w_selCtrl;
    logic [AW-1:0]      w_selAmt;
    logic [WIDTH-1:0]   w_shData;
    logic               w_shErr;

    // Accepting is allowed when the buffer is free or is being drained this
    // cycle; nothing is accepted while reset is asserted.
    assign w_canAccept = ~i_rst & ((r_state == BUF_EMPTY) | i_rsp_ready);
    assign w_grant     = w_canAccept & (|i_req_valid);

    // Rotate the valid vector so rr_ptr sits at bit 0, then the lowest set
    // bit is the winner's distance from rr_ptr.
    assign w_validDbl = {i_req_valid, i_req_valid} >> r_rrPtr;
    assign w_validRot = w_validDbl[N-1:0];

    // Priority search: scanning downward leaves the lowest set offset.
    always_comb begin
        w_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_validRot[k]) w_offset = IDW'(k);
        end
    end

    // Map the offset back to an absolute index; N need not be a power of two.
    assign w_sum      = {1'b0, r_rrPtr} + {1'b0, w_offset};
    assign w_grantIdx = (w_sum >= NVAL) ? IDW'(w_sum - NVAL) : w_sum[IDW-1:0];
    assign w_nextPtr  = (w_grantIdx == IDW'(N - 1)) ? '0 : w_grantIdx + IDW'(1);

    assign o_req_ready = w_grant ? (N'(1) << w_grantIdx) : '0;

    // Steer the granted requester's fields into the shared shifter.
    always_comb begin
        w_selData = '0;
        w_selCtrl = '0;
        w_selAmt  = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grantIdx == IDW'(k)) begin
                w_selData = i_req_data[k*WIDTH +: WIDTH];
                w_selCtrl = i_req_ctrl[k*3 +: 3];
                w_selAmt  = i_req_amt[k*AW +: AW];
            end
        end
    end

    shifter_barrel #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_barrel (
        .i_data (w_selData),
        .i_ctrl (w_selCtrl),
        .i_amt  (w_selAmt),
        .o_data (w_shData),
        .o_err  (w_shErr)
    );

    // Buffer state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= BUF_EMPTY;
        else       r_state <= w_nextState;
    end

    // A grant always fills the buffer (covering drain-and-refill in one
    // cycle); an accepted response with nothing new empties it.
    always_comb begin
        w_nextState = r_state;
        if (w_grant)
            w_nextState = BUF_FULL;
        else if ((r_state == BUF_FULL) && i_rsp_ready)
            w_nextState = BUF_EMPTY;
    end

    // Response valid mirrors the buffer state, held low during reset.
    always_comb begin
        o_rsp_valid = (r_state == BUF_FULL) && !i_rst;
    end

    // Payload and round-robin pointer only move on a grant, so a stalled
    // response stays stable and the pointer is preserved across stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rspData <= '0;
            r_rspId   <= '0;
            r_rspErr  <= 1'b0;
            r_rrPtr   <= '0;
        end else if (w_grant) begin
            r_rspData <= w_shData;
            r_rspId   <= w_grantIdx;
            r_rspErr  <= w_shErr;
            r_rrPtr   <= w_nextPtr;
        end
    end

    assign o_rsp_data = r_rspData;
    assign o_rsp_id   = r_rspId;
    assign o_rsp_err  = r_rspErr;

endmodule

// File: tb/tb_shifter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_shifter_rr_scheduler
// Self-checking bench for shifter_rr_scheduler (WIDTH=8, N=4): a directed
// vector table, a bit-level reference model feeding a response scoreboard,
// and hand-written sequences for reset, fairness, backpressure and wrap.
// -----------------------------------------------------------------------------
module tb_shifter_rr_scheduler;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int AW    = 4;
    localparam int IDW   = 2;

    logic               i_clk;
    logic               i_rst;
    logic [N-1:0]       i_req_valid;
    logic [N-1:0]       o_req_ready;
    logic [N*WIDTH-1:0] i_req_data;
    logic [N*3-1:0]     i_req_ctrl;
    logic [N*AW-1:0]    i_req_amt;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [WIDTH-1:0]   o_rsp_data;
    logic [IDW-1:0]     o_rsp_id;
    logic               o_rsp_err;

    typedef struct {
        logic [7:0] data;
        logic [2:0] ctrl;
        logic [3:0] amt;
        logic [7:0] expData;
        logic       expErr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
        logic       err;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;
    bit   monEn    = 0;
    bit   expectRsp = 0;
    rsp_t sbQ[$];
    vec_t vecs[7];

    shifter_rr_scheduler #(.WIDTH(WIDTH), .N(N)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_data  (i_req_data),
        .i_req_ctrl  (i_req_ctrl),
        .i_req_amt   (i_req_amt),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_err   (o_rsp_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Bit-by-bit reference model of the shifter.
    function automatic logic [7:0] modelShift(logic [7:0] d, logic [2:0] c, logic [3:0] a);
        logic [7:0] r;
        int amt;
        int m;
        amt = int'(a);
        m   = amt % 8;
        r   = d;
        for (int i = 0; i < 8; i++) begin
            case (c)
                3'b001: if (m != 0) r[i] = (i + amt < 8) ? d[i + amt] : 1'b0;
                3'b010: r[i] = (i + m < 8) ? d[i + m] : d[7];
                3'b011: r[i] = d[(i + m) % 8];
                3'b100: if (m != 0) r[i] = (i - amt >= 0) ? d[i - amt] : 1'b0;
                3'b110: r[i] = d[(i - m + 8) % 8];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    // Count one comparison and report it when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic setReq(input int k, input logic [7:0] d, input logic [2:0] c, input logic [3:0] a);
        i_req_data[k*8 +: 8] = d;
        i_req_ctrl[k*3 +: 3] = c;
        i_req_amt[k*4 +: 4]  = a;
    endtask

    // Present one request alone on requester k and wait for its handshake.
    task automatic applyStimulus(input int k, input logic [7:0] d, input logic [2:0] c, input logic [3:0] a);
        bit seen;
        seen = 0;
        setReq(k, d, c, a);
        i_req_valid = N'(1) << k;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge i_clk);
            if (o_req_ready[k]) begin
                seen = 1;
                break;
            end
            stepCycle();
        end
        if (!seen) begin
            checkOutput("grant_timeout", 32'(o_req_ready), 32'(N'(1) << k));
        end
        stepCycle();
        i_req_valid = '0;
    endtask

    // Scoreboard: pop and compare each consumed response, then push the
    // model's prediction for whatever is granted this cycle.
    always @(negedge i_clk) begin
        if (i_rst || !monEn) begin
            expectRsp = 0;
        end else begin
            rsp_t exp;
            if (expectRsp) checkOutput("latency_valid", 32'(o_rsp_valid), 32'd1);
            if (o_rsp_valid && i_rsp_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("sb_unexpected_rsp", 32'(o_rsp_valid), 32'd0);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("sb_rsp", {21'd0, o_rsp_err, o_rsp_id, o_rsp_data},
                                {21'd0, exp.err, exp.id, exp.data});
                end
            end
            expectRsp = 0;
            if (|o_req_ready) begin
                checkOutput("ready_onehot", 32'($onehot(o_req_ready)), 32'd1);
                for (int k = 0; k < N; k++) begin
                    if (o_req_ready[k]) begin
                        exp.id   = 2'(k);
                        exp.data = modelShift(i_req_data[k*8 +: 8], i_req_ctrl[k*3 +: 3], i_req_amt[k*4 +: 4]);
                        exp.err  = (i_req_ctrl[k*3 +: 3] == 3'b101) || (i_req_ctrl[k*3 +: 3] == 3'b111);
                        sbQ.push_back(exp);
                    end
                end
                expectRsp = 1;
            end
        end
    end

    initial begin
        logic [7:0] holdData;

        vecs[0] = '{data: 8'h96, ctrl: 3'b010, amt: 4'd2, expData: 8'hE5, expErr: 1'b0};
        vecs[1] = '{data: 8'h81, ctrl: 3'b011, amt: 4'd1, expData: 8'hC0, expErr: 1'b0};
        vecs[2] = '{data: 8'h81, ctrl: 3'b110, amt: 4'd9, expData: 8'h03, expErr: 1'b0};
        vecs[3] = '{data: 8'h0F, ctrl: 3'b100, amt: 4'd4, expData: 8'hF0, expErr: 1'b0};
        vecs[4] = '{data: 8'h80, ctrl: 3'b001, amt: 4'd9, expData: 8'h00, expErr: 1'b0};
        vecs[5] = '{data: 8'h80, ctrl: 3'b001, amt: 4'd8, expData: 8'h80, expErr: 1'b0};
        vecs[6] = '{data: 8'h5A, ctrl: 3'b101, amt: 4'd3, expData: 8'h5A, expErr: 1'b1};

        i_rst       = 1'b1;
        i_req_valid = '1;
        i_rsp_ready = 1'b1;
        i_req_data  = '0;
        i_req_ctrl  = '0;
        i_req_amt   = '0;
        for (int k = 0; k < N; k++) setReq(k, 8'(8'h11 * (k + 3)), 3'(k), 4'(k + 1));
        monEn = 1;

        // Reset held for two edges with everyone requesting.
        for (int r = 0; r < 2; r++) begin
            stepCycle();
            @(negedge i_clk);
            checkOutput("rst_req_ready", 32'(o_req_ready), 32'd0);
            checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
            checkOutput("rst_rsp_data",  32'(o_rsp_data),  32'd0);
            checkOutput("rst_rsp_id",    32'(o_rsp_id),    32'd0);
            checkOutput("rst_rsp_err",   32'(o_rsp_err),   32'd0);
        end
        stepCycle();
        i_rst = 1'b0;

        // Fairness: all valid, ready high -> grants 0,1,2,3,0,... no gaps.
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            checkOutput("fair_grant", 32'(o_req_ready), 32'(4'b0001 << (k % 4)));
            if (k > 0) begin
                checkOutput("fair_rsp_valid", 32'(o_rsp_valid), 32'd1);
                checkOutput("fair_rsp_id",    32'(o_rsp_id),    32'((k - 1) % 4));
            end
            stepCycle();
        end
        i_req_valid = '0;
        @(negedge i_clk);
        checkOutput("fair_last_id", 32'(o_rsp_id), 32'd3);
        checkOutput("fair_idle_ready", 32'(o_req_ready), 32'd0);
        stepCycle();

        // Directed vector table, each on a different requester.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i % 4, vecs[i].data, vecs[i].ctrl, vecs[i].amt);
            @(negedge i_clk);
            checkOutput($sformatf("vec%0d_valid", i), 32'(o_rsp_valid), 32'd1);
            checkOutput($sformatf("vec%0d_data", i),  32'(o_rsp_data),  32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_id", i),    32'(o_rsp_id),    32'(i % 4));
            checkOutput($sformatf("vec%0d_err", i),   32'(o_rsp_err),   32'(vecs[i].expErr));
            stepCycle();
        end

        // Backpressure: pointer is 3 here; fill buffer from requester 0.
        i_rsp_ready = 1'b0;
        holdData    = 8'h3C;
        setReq(0, holdData, 3'b000, 4'd0);
        i_req_valid = 4'b0001;
        @(negedge i_clk);
        checkOutput("bp_fill_grant", 32'(o_req_ready), 32'b0001);
        stepCycle();
        setReq(0, 8'hA5, 3'b100, 4'd1);
        setReq(1, 8'hC3, 3'b001, 4'd2);
        i_req_valid = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            checkOutput("bp_ready_low", 32'(o_req_ready), 32'd0);
            checkOutput("bp_hold_valid", 32'(o_rsp_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(o_rsp_data), 32'(holdData));
            checkOutput("bp_hold_id", 32'(o_rsp_id), 32'd0);
            stepCycle();
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("bp_release_grant", 32'(o_req_ready), 32'b0010);
        stepCycle();
        i_req_valid = 4'b0001;
        @(negedge i_clk);
        checkOutput("bp_nobubble_valid", 32'(o_rsp_valid), 32'd1);
        checkOutput("bp_nobubble_id", 32'(o_rsp_id), 32'd1);
        checkOutput("bp_next_grant", 32'(o_req_ready), 32'b0001);
        stepCycle();
        i_req_valid = '0;
        @(negedge i_clk);
        checkOutput("bp_final_id", 32'(o_rsp_id), 32'd0);
        stepCycle();

        // Sparse and wrap: move pointer to 2, then requesters 3 and 1.
        applyStimulus(1, 8'h44, 3'b000, 4'd0);
        @(negedge i_clk);
        checkOutput("sparse_pre_id", 32'(o_rsp_id), 32'd1);
        stepCycle();
        setReq(3, 8'hF0, 3'b011, 4'd4);
        setReq(1, 8'h0C, 3'b010, 4'd1);
        i_req_valid = 4'b1010;
        @(negedge i_clk);
        checkOutput("sparse_first", 32'(o_req_ready), 32'b1000);
        stepCycle();
        i_req_valid = 4'b0010;
        @(negedge i_clk);
        checkOutput("sparse_second", 32'(o_req_ready), 32'b0010);
        checkOutput("sparse_rsp3", 32'(o_rsp_id), 32'd3);
        stepCycle();
        i_req_valid = 4'b1111;
        @(negedge i_clk);
        checkOutput("sparse_rsp1", 32'(o_rsp_id), 32'd1);
        checkOutput("sparse_ptr2", 32'(o_req_ready), 32'b0100);
        stepCycle();
        i_req_valid = '0;

        repeat (3) stepCycle();
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/shifter_rr_scheduler.md
# shifter_rr_scheduler

Round-robin scheduler that shares a single combinational barrel-shifter datapath among N independent requesters. Each requester presents data, a 3-bit shift control and a shift amount over a valid/ready handshake. The scheduler grants one request per cycle, registers the shift result with the winning requester ID into a one-entry output buffer, and returns it on a valid/ready response channel. It sits between per-lane ALU front ends and the shared shifter in the common datapath library.

## Interface
- WIDTH, 8: data width; power of two, ≥ 4.
- N, 4: number of requesters; 2..16.
- AW, $clog2(WIDTH)+1: shift-amount width (derived, not overridable).
- IDW, $clog2(N): requester-ID width (derived).

- i_clk, input, 1: clock; all logic rising-edge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_req_valid, input, N: per-requester request valid.
- o_req_ready, output, N: per-requester accept; one-hot or zero.
- i_req_data, input, N*WIDTH: packed operands; requester k at [k*WIDTH +: WIDTH].
- i_req_ctrl, input, N*3: packed shift controls.
- i_req_amt, input, N*AW: packed shift amounts.
- o_rsp_valid, output, 1: response valid.
- i_rsp_ready, input, 1: response accept.
- o_rsp_data, output, WIDTH: shifted result.
- o_rsp_id, output, IDW: index of the originating requester.
- o_rsp_err, output, 1: 1 when ctrl was an illegal code (101 or 111).

## Operation
- Ctrl encoding:
  - 000: pass.
  - 001: logical right.
  - 010: arithmetic right by amt mod WIDTH.
  - 011: rotate right by amt mod WIDTH.
  - 100: logical left.
  - 110: rotate left by amt mod WIDTH.
  - 101 and 111: illegal; data passes unchanged and err=1.
- Logical shifts:
  - Shift by the raw amt, so a result of 0 is possible when amt ≥ WIDTH.
  - When amt mod WIDTH = 0, the output equals the input.
- Output-buffer FSM:
  - EMPTY: o_rsp_valid=0.
  - FULL: o_rsp_valid=1; data, id and err stay stable until accepted.
- can_accept = EMPTY | (FULL & i_rsp_ready).
- Arbitration:
  - When can_accept and any i_req_valid is set, grant the first valid requester at or after rr_ptr, searching upward with wrap.
  - Assert o_req_ready for that requester only.
- On grant:
  - The buffer loads the shifter output, ID and err; state goes to or stays FULL.
  - rr_ptr becomes grant+1 mod N.
- Transitions:
  - FULL with i_rsp_ready and no valid request: go to EMPTY.
  - FULL without i_rsp_ready: hold; all o_req_ready=0.
- rr_ptr changes only on a grant.
- Requesters hold data, ctrl and amt stable while valid and not yet accepted. The scheduler does not check this.

## Timing
- Reset values: o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_rsp_err=0, rr_ptr=0, state EMPTY.
- Reset mid-operation discards any buffered response; no handshake completes in the reset cycle.
- o_req_ready is combinational from i_req_valid, state, i_rsp_ready and rr_ptr. It never depends on i_req_data.
- Latency: a request accepted in cycle t appears on the response channel in cycle t+1.
- Throughput: one result per cycle when i_rsp_ready is held high.
- Same-cycle drain and refill in FULL state is required; no bubble is allowed.
- Fairness: a continuously valid requester is granted within N grants.

## Structure
- Package shifter_pkg:
  - shift_ctrl_e enum: SH_NONE, SH_LSR, SH_ASR, SH_RSR_WRAP, SH_LSL, SH_LSL_WRAP.
  - buffer-state enum.
  - is_illegal_ctrl() function.
- Sub-module: one shifter_barrel instance. Its inputs are muxed from the granted requester; its output is registered in this block.
- The round-robin grant is inline: a double-width priority search over the valid vector rotated by rr_ptr.

## Test plan
- Reset: assert i_rst for 2 cycles while requesters are valid. All outputs are 0 throughout; the first grant afterward goes to requester 0.
- Single requests (WIDTH=8), each response in the next cycle with the correct id:
  - 0x96, ctrl 010, amt 2 gives 0xE5.
  - 0x81, ctrl 011, amt 1 gives 0xC0.
  - 0x81, ctrl 110, amt 9 gives 0x03.
  - 0x0F, ctrl 100, amt 4 gives 0xF0.
  - 0x80, ctrl 001, amt 9 gives 0x00.
  - 0x80, ctrl 001, amt 8 gives 0x80.
- Illegal ctrl: 0x5A with ctrl 101 gives 0x5A and err=1.
- Fairness: all 4 requesters valid continuously, i_rsp_ready=1. Response IDs are 0,1,2,3,0,… with one response per cycle and no gaps.
- Backpressure: hold i_rsp_ready=0 for 5 cycles with requests pending. Response stays stable, all o_req_ready=0, rr_ptr is unchanged. Releasing ready completes drain and the next grant in the same cycle.
- Sparse and wrap: only requesters 3 and 1 valid with rr_ptr=2. Grant order is 3 then 1, and rr_ptr ends at 2.
